i_fetch: RTL and testbench

I_FETCH -- requirements
Module: i_fetch

---
 rtl/i_fetch.sv | 85 ++++++++
 tb/tb_i_fetch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/i_fetch.sv
// i_fetch: instruction fetch stage with IF/ID register, 1-entry stall buffer and redirect.
// Optional delivered-instruction counter is built only when IF_PERF_CNT_EN is defined.
module i_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] target_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic        valid_out,
  output logic [31:0] fetch_count_out
);
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_q, buf_d, instr_q, instr_d, npc_q, npc_d;
  logic        valid_q, valid_d, hs, deliver;
  logic [31:0] pc_inc;
  assign pc_inc          = pc_q + 32'd4;
  assign imem_req_out    = rst_n && state_q == FETCH;
  assign imem_addr_out   = pc_q;
  assign hs              = imem_req_out && imem_ready_in;
  assign deliver         = !redirect_in && !stall_in && (state_q == HOLD || hs);
  assign instruction_out = instr_q;
  assign npc_out         = npc_q;
  assign valid_out       = valid_q;
  // While in HOLD the pc still points at the buffered word, so pc+4 is its npc.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (redirect_in) begin
      state_d = FETCH;
      pc_d    = target_in & ~32'h3;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall_in) begin
      state_d = FETCH;
      valid_d = deliver;
      instr_d = state_q == HOLD ? buf_q : hs ? imem_rdata_in : '0;
      npc_d   = deliver ? pc_inc : npc_q;
      pc_d    = deliver ? pc_inc : pc_q;
    end else if (hs) begin
      state_d = HOLD;
      buf_d   = imem_rdata_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC & ~32'h3;
      buf_q   <= '0;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end
`ifdef IF_PERF_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (deliver && cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
  end
  assign fetch_count_out = cnt_q;
`else
  assign fetch_count_out = '0;
`endif
endmodule

// File: tb/tb_i_fetch.sv
// tb_i_fetch: directed checks of i_fetch with hand-computed expected values.
module tb_i_fetch;
  logic        clk = 1'b0;
  logic        rst_n, stall_in, redirect_in, imem_ready_in, imem_req_out, valid_out;
  logic [31:0] target_in, imem_addr_out, imem_rdata_in, instruction_out, npc_out, fetch_count_out;
  logic        fix_en;
  logic [31:0] fix_word;
  int          n_tests = 0;
  int          n_fail  = 0;
  always #5 clk = ~clk;
  always_comb imem_rdata_in = fix_en ? fix_word : ~imem_addr_out;
  i_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .redirect_in(redirect_in),
    .target_in(target_in), .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ready_in(imem_ready_in), .imem_rdata_in(imem_rdata_in),
    .instruction_out(instruction_out), .npc_out(npc_out), .valid_out(valid_out),
    .fetch_count_out(fetch_count_out)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; target_in = '0;
    imem_ready_in = 1'b1; fix_en = 1'b0; fix_word = '0;
    tick; tick;
    check("rst_req", imem_req_out, 0);
    check("rst_addr", imem_addr_out, 32'h100);
    check("rst_instr", instruction_out, 0);
    check("rst_npc", npc_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_cnt", fetch_count_out, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("first_req", imem_req_out, 1);
    check("first_addr", imem_addr_out, 32'h100);
    for (int i = 1; i <= 3; i++) begin
      tick;
      check("seq_npc", npc_out, 32'h100 + 32'(4 * i));
      check("seq_valid", valid_out, 1);
    end
    check("seq_instr", instruction_out, ~32'h108);
    redirect_in = 1'b1; target_in = 32'h40;
    tick;
    redirect_in = 1'b0; imem_ready_in = 1'b0;
    check("rd40_valid", valid_out, 0);
    check("rd40_instr", instruction_out, 0);
    check("rd40_addr", imem_addr_out, 32'h40);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("wait_addr", imem_addr_out, 32'h40);
      check("wait_valid", valid_out, 0);
      check("wait_req", imem_req_out, 1);
    end
    imem_ready_in = 1'b1;
    tick;
    check("wait_instr", instruction_out, ~32'h40);
    check("wait_npc", npc_out, 32'h44);
    check("wait_next", imem_addr_out, 32'h44);
    fix_en = 1'b1; fix_word = 32'hDEAD_BEEF; stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      check("stall_instr", instruction_out, ~32'h40);
      check("stall_npc", npc_out, 32'h44);
      check("stall_valid", valid_out, 1);
      check("hold_req", imem_req_out, 0);
      check("hold_addr", imem_addr_out, 32'h44);
    end
    stall_in = 1'b0; fix_en = 1'b0;
    tick;
    check("unstall_instr", instruction_out, 32'hDEAD_BEEF);
    check("unstall_npc", npc_out, 32'h48);
    check("unstall_valid", valid_out, 1);
    check("unstall_addr", imem_addr_out, 32'h48);
    tick;
    check("after_npc", npc_out, 32'h4C);
    stall_in = 1'b1; redirect_in = 1'b1; target_in = 32'h2002;
    tick;
    stall_in = 1'b0; redirect_in = 1'b0;
    check("flush_valid", valid_out, 0);
    check("flush_instr", instruction_out, 0);
    check("flush_addr", imem_addr_out, 32'h2000);
    check("flush_req", imem_req_out, 1);
    tick;
    check("flush_next_instr", instruction_out, ~32'h2000);
    check("flush_next_npc", npc_out, 32'h2004);
    redirect_in = 1'b1; target_in = 32'hFFFF_FFFC;
    tick;
    redirect_in = 1'b0;
    check("wrap_addr", imem_addr_out, 32'hFFFF_FFFC);
    tick;
    check("wrap_npc", npc_out, 32'h0);
    check("wrap_instr", instruction_out, 32'h3);
    check("wrap_addr0", imem_addr_out, 32'h0);
    tick;
    check("wrap_npc4", npc_out, 32'h4);
    stall_in = 1'b1; imem_ready_in = 1'b0;
    tick;
    check("idle_stall_valid", valid_out, 1);
    check("idle_stall_npc", npc_out, 32'h4);
    stall_in = 1'b0;
    tick;
    check("bubble_valid", valid_out, 0);
    check("bubble_instr", instruction_out, 0);
    check("bubble_npc", npc_out, 32'h4);
    imem_ready_in = 1'b1;
    tick;
    check("resume_npc", npc_out, 32'h8);
`ifdef IF_PERF_CNT_EN
    check("cnt_ten", fetch_count_out, 32'd10);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    tick; tick;
    check("cnt_sat", fetch_count_out, 32'hFFFF_FFFF);
`else
    check("cnt_off", fetch_count_out, 32'd0);
`endif
    stall_in = 1'b1;
    tick;
    check("pre_rst_req", imem_req_out, 0);
    rst_n = 1'b0;
    #1;
    check("hold_rst_valid", valid_out, 0);
    check("hold_rst_instr", instruction_out, 0);
    check("hold_rst_req", imem_req_out, 0);
    check("hold_rst_addr", imem_addr_out, 32'h100);
    stall_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rerst_req", imem_req_out, 1);
    tick;
    check("rerst_instr", instruction_out, ~32'h100);
    check("rerst_npc", npc_out, 32'h104);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
